// File: rtl/phase_sequencer_pkg.sv
// Shared state encoding for the LEGv8 phase sequencer.
// The state register, the next-state logic and any debug probes all use this one enum.
package legv8_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    HOLD      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    MEMORY    = 3'd3,
    MEM_WAIT  = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6
  } seq_state_t;

  // A cycle is active when the sequencer is running an instruction.
  function automatic logic is_active(seq_state_t s);
    return (s == FETCH) || (s == DECODE) || (s == MEMORY) ||
           (s == MEM_WAIT) || (s == WRITEBACK);
  endfunction

endpackage

// File: rtl/phase_sequencer_if.sv
// Groups the sequencer's datapath-facing signals.
// The sequencer takes the master modport. The datapath and the memory take the slave modport.
interface phase_sequencer_if #(
  parameter int CNT_WIDTH = 32
);

  logic                 mem_access;
  logic                 mem_ready;
  logic                 halt_req;
  logic                 core_reset;
  logic                 fetch_en;
  logic                 read_en;
  logic                 mem_en;
  logic                 write_en;
  logic                 pc_update_en;
  logic                 halted;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] retired_count;
  logic [CNT_WIDTH-1:0] cycle_count;

  modport master (
    input  mem_access, mem_ready, halt_req,
    output core_reset, fetch_en, read_en, mem_en, write_en, pc_update_en,
           halted, timeout, retired_count, cycle_count
  );

  modport slave (
    output mem_access, mem_ready, halt_req,
    input  core_reset, fetch_en, read_en, mem_en, write_en, pc_update_en,
           halted, timeout, retired_count, cycle_count
  );

endinterface

// File: rtl/phase_sequencer_sat_counter.sv
// Up-counter that has an enable and a synchronous clear.
// It saturates at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (en && !(&count_reg)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/phase_sequencer.sv
// Single-clock phase sequencer for the non-pipelined LEGv8 datapath. It generates one-hot enables
// for fetch, decode, memory and writeback. It also handles the post-reset hold, memory stalls with timeout and halting.
module phase_sequencer
  import legv8_seq_pkg::*;
#(
  parameter int RESET_HOLD_CYCLES = 6,
  parameter int MEM_WAIT_MAX      = 16,
  parameter int INSTR_LIMIT       = 500,
  parameter int CNT_WIDTH         = 32
) (
  input  logic               clk,
  input  logic               reset,
  phase_sequencer_if.master  seq
);

  localparam int HOLD_W = (RESET_HOLD_CYCLES > 0) ? $clog2(RESET_HOLD_CYCLES + 1) : 1;
  localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);

  seq_state_t        state_reg, state_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [WAIT_W-1:0] wait_inc;
  logic              halt_pending_reg, halt_pending_next;
  logic              timeout_reg, timeout_next;

  logic [CNT_WIDTH-1:0] retired_count;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [CNT_WIDTH-1:0] retired_inc;
  logic                 limit_hit;

  logic [CNT_WIDTH-1:0] cnt_value [2];
  logic                 cnt_en    [2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= HOLD;
      hold_cnt_reg     <= HOLD_W'(RESET_HOLD_CYCLES);
      wait_cnt_reg     <= '0;
      halt_pending_reg <= 1'b0;
      timeout_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      wait_cnt_reg     <= wait_cnt_next;
      halt_pending_reg <= halt_pending_next;
      timeout_reg      <= timeout_next;
    end
  end

  // The limit compares against the count this retirement produces, so the sequencer halts right after instruction INSTR_LIMIT.
  assign retired_inc = (&retired_count) ? retired_count : retired_count + 1'b1;
  assign limit_hit   = (INSTR_LIMIT != 0) && (retired_inc == CNT_WIDTH'(INSTR_LIMIT));
  assign wait_inc    = wait_cnt_reg + 1'b1;

  always_comb begin
    state_next        = state_reg;
    hold_cnt_next     = hold_cnt_reg;
    wait_cnt_next     = wait_cnt_reg;
    halt_pending_next = halt_pending_reg;
    timeout_next      = timeout_reg;

    if (is_active(state_reg)) begin
      halt_pending_next = halt_pending_reg | seq.halt_req;
    end

    case (state_reg)
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          state_next = FETCH;
        end else begin
          hold_cnt_next = hold_cnt_reg - 1'b1;
        end
      end
      FETCH:  state_next = DECODE;
      DECODE: state_next = MEMORY;
      MEMORY: begin
        if (seq.mem_access && !seq.mem_ready) begin
          state_next    = MEM_WAIT;
          wait_cnt_next = '0;
        end else begin
          state_next = WRITEBACK;
        end
      end
      MEM_WAIT: begin
        // If ready arrives in the same cycle the counter reaches the limit, ready wins and the instruction retires.
        if (seq.mem_ready) begin
          state_next = WRITEBACK;
        end else if (wait_inc == WAIT_W'(MEM_WAIT_MAX)) begin
          state_next   = HALTED;
          timeout_next = 1'b1;
        end else begin
          wait_cnt_next = wait_inc;
        end
      end
      WRITEBACK: begin
        if (halt_pending_reg || seq.halt_req || limit_hit) begin
          state_next = HALTED;
        end else begin
          state_next = FETCH;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = HOLD;
    endcase
  end

  assign cnt_en[0] = (state_reg == WRITEBACK);
  assign cnt_en[1] = is_active(state_reg);

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_counters
      sat_counter #(
        .WIDTH (CNT_WIDTH)
      ) u_cnt (
        .clk   (clk),
        .clear (reset),
        .en    (cnt_en[gi]),
        .count (cnt_value[gi])
      );
    end
  endgenerate

  assign retired_count = cnt_value[0];
  assign cycle_count   = cnt_value[1];

  assign seq.core_reset    = (state_reg == HOLD);
  assign seq.fetch_en      = (state_reg == FETCH);
  assign seq.read_en       = (state_reg == DECODE);
  assign seq.mem_en        = (state_reg == MEMORY) || (state_reg == MEM_WAIT);
  assign seq.write_en      = (state_reg == WRITEBACK);
  assign seq.pc_update_en  = (state_reg == WRITEBACK);
  assign seq.halted        = (state_reg == HALTED);
  assign seq.timeout       = timeout_reg;
  assign seq.retired_count = retired_count;
  assign seq.cycle_count   = cycle_count;

endmodule

// File: doc/phase_sequencer.md
Name: phase_sequencer

Overview:
- Single-clock replacement for the free-running oscillator plus the delay-chain phase clocks (instruction-memory, register-read, memory, register-write) that drive the nonpipelined LEGv8 datapath.
- Produces one-hot, registered phase enables per instruction.
- Supports a stalling memory handshake with timeout, a programmable post-reset hold, a halt request and an optional retired-instruction limit.
- Sits at the datapath top level; Fetch/Decode/Execute/Memory consume its enables instead of skewed clocks.

Parameters:
- RESET_HOLD_CYCLES, 6: cycles core_reset stays high after reset deasserts; 0 means core_reset drops on the first cycle.
- MEM_WAIT_MAX, 16: maximum MEM_WAIT cycles before timeout; must be at least 1.
- INSTR_LIMIT, 500: retire this many instructions, then halt; 0 means unlimited.
- CNT_WIDTH, 32: width of retired_count and cycle_count.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- mem_access  in  1  current instruction uses data memory (mem_read|mem_write); sampled in MEMORY
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  request stop at next instruction boundary
- core_reset  out  1  reset to datapath state elements
- fetch_en  out  1  PC/instruction-memory phase
- read_en  out  1  register-file read / decode phase
- mem_en  out  1  execute + data-memory phase
- write_en  out  1  register writeback phase
- pc_update_en  out  1  PC loads next value (coincides with write_en)
- halted  out  1  sequencer stopped
- timeout  out  1  memory wait exceeded MEM_WAIT_MAX
- retired_count  out  CNT_WIDTH  instructions completed
- cycle_count  out  CNT_WIDTH  active (non-HOLD, non-HALTED) cycles

Behaviour:
- Reset is synchronous and active-high; one clock, clk.
- Reset values: state HOLD, hold counter = RESET_HOLD_CYCLES, core_reset=1, all enables 0, halted=0, timeout=0, counters 0, halt_pending=0.
- Reset asserted in any state, including mid MEM_WAIT, returns everything to the reset values at the next edge. No partial instruction retires.
- Outputs are Moore outputs decoded from registered state. An enable is high exactly during the cycle its state is current. At most one of fetch_en, read_en, mem_en and write_en is high.
- HOLD: core_reset=1. The counter decrements each cycle; when it reads 0, go to FETCH and drop core_reset. With RESET_HOLD_CYCLES=6, core_reset is high 7 cycles after reset falls.
- FETCH -> DECODE -> MEMORY, one cycle each.
- MEMORY: if mem_access & !mem_ready, go to MEM_WAIT and clear the wait counter; otherwise go to WRITEBACK. A same-cycle ready means no stall.
- MEM_WAIT: mem_en stays 1 and the wait counter increments.
  - mem_ready: go to WRITEBACK. Ready wins if it arrives in the same cycle the counter reaches MEM_WAIT_MAX.
  - Counter reaches MEM_WAIT_MAX without ready: go to HALTED with timeout=1; the instruction does not retire.
- WRITEBACK: write_en=1, pc_update_en=1; retired_count increments, saturating at all-ones.
  - Next state is HALTED if halt_pending, halt_req this cycle, or (INSTR_LIMIT≠0 and the new retired_count == INSTR_LIMIT).
  - Otherwise the next state is FETCH.
- halt_req is latched into halt_pending whenever the state is outside HOLD/HALTED. It takes effect only at the WRITEBACK boundary, so the current instruction always completes.
- HALTED: all enables 0, halted=1, core_reset=0. Stays until reset; counters frozen, timeout held.
- cycle_count increments, saturating, in every FETCH/DECODE/MEMORY/MEM_WAIT/WRITEBACK cycle.
- Nominal latency is 4 cycles per instruction, plus wait cycles.

Decomposition:
- Shared package legv8_seq_pkg holds the state enum typedef (HOLD, FETCH, DECODE, MEMORY, MEM_WAIT, WRITEBACK, HALTED) and its encoding width.
- One sub-module is natural: sat_counter (parametrised width, enable, sync clear), instantiated for retired_count and cycle_count.

Test Plan:
- Reset pulse 1 cycle, RESET_HOLD_CYCLES=6 -> core_reset high 7 cycles after reset falls; first fetch_en on the 8th cycle.
- 3 instructions, mem_access=0 -> enable pattern F,R,M,W repeats with period 4; retired_count=3, cycle_count=12 after the third write_en.
- mem_access=1, mem_ready raised after 3 wait cycles -> mem_en high 4 cycles, then write_en; retired_count increments by 1.
- mem_ready never, MEM_WAIT_MAX=16 -> after 16 MEM_WAIT cycles halted=1 and timeout=1; retired_count unchanged; also check the ready-at-16 corner, which retires.
- halt_req pulsed in DECODE of instruction 5 -> instruction 5 retires, then halted=1 with retired_count=5; INSTR_LIMIT=500 run halts at exactly 500.
- Reset asserted in MEM_WAIT -> next edge is HOLD with all outputs at reset values; timeout=0 and counters=0.
